spio_aer_pkt_arbiter: RTL and testbench
=======================================

Name: spio_aer_pkt_arbiter

Overview:
- Merges SpiNNaker packet streams from NUM_IN AER-to-SpiNNaker mappers (e.g. two retinas, or a retina plus a cochlea) onto one SpiNNaker link transmitter packet interface.
- Uses fair round-robin arbitration with per-input enable masking.
- Registers the output so a full 72-bit packet forwards at up to one per cycle.
- Sits between the mapper instances and the spinnaker_link transmitter.

Parameters:
- NUM_IN, 2, number of packet inputs (legal range 2..4).
- PKT_BITS, 72, packet width. Data and parity pass through unmodified.

Ports:
- rst  input  1  reset: asynchronous, active-high.
- clk  input  1  clock.
- in_enable  input  NUM_IN  per-input enable mask, static or quasi-static.
- in_data  input  NUM_IN*PKT_BITS  input packets; input i occupies bits [i*PKT_BITS +: PKT_BITS].
- in_vld  input  NUM_IN  per-input valid.
- in_rdy  output  NUM_IN  per-input ready.
- out_data  output  PKT_BITS  merged packet, registered.
- out_vld  output  1  merged valid, registered.
- out_rdy  input  1  downstream ready.
- pkt_count  output  16  count of packets forwarded to the output, registered.

Behaviour:
- Handshake (all interfaces): a transfer occurs on a rising clk edge where vld && rdy.
  - Once raised, vld and data hold stable until the transfer.
  - vld must not depend combinationally on rdy.
- Reset values: out_vld=0, out_data=0, pkt_count=0, last_grant=NUM_IN-1. Input 0 therefore wins the first arbitration.
- load = !out_vld || out_rdy. The output register can accept a packet this cycle.
- req[i] = in_vld[i] && in_enable[i].
- Grant selection (combinational):
  - Search starts at (last_grant+1) mod NUM_IN and wraps.
  - The first i with req[i] set is granted.
  - With no requests there is no grant.
- in_rdy[i] = load && granted(i). At most one in_rdy is high in any cycle.
  - in_rdy is combinational from in_vld, in_enable, out_vld, out_rdy and last_grant.
- On a grant with load:
  - out_data <= the granted input's packet.
  - out_vld <= 1.
  - last_grant <= i.
  - pkt_count <= pkt_count+1.
- On load with no grant: out_vld <= 0, out_data unchanged.
- When !load: out_vld, out_data, last_grant and pkt_count all hold.
- Latency: 1 cycle from input transfer to out_vld.
- Throughput: 1 packet per cycle when out_rdy is held high.
- Fairness: with all NUM_IN inputs continuously requesting, grants rotate 0,1,…,NUM_IN-1,0,…
  - No input waits more than NUM_IN-1 transfers.
- last_grant updates only on an actual transfer. A stalled output never advances priority.
- Disabled input (in_enable[i]=0): never granted and in_rdy[i]=0, so its packet stalls upstream and is not dropped.
  - Re-enabling the input resumes normal arbitration.
  - Clearing in_enable[i] has no effect on a packet already in the output register; that packet still delivers.
- Simultaneous events:
  - Output transfer and new input transfer in the same cycle: the new packet replaces the old one with no bubble.
  - pkt_count counts input-side transfers.
- pkt_count wraps from 0xFFFF to 0x0000.
- Reset mid-operation: a packet held in the output register is discarded, out_vld drops immediately (asynchronously), and priority returns to input 0.
- No packet contents are inspected or altered. Parity is the upstream mapper's responsibility.

Test Plan:
- Single source: NUM_IN=2, enable=2'b11, in0 sends 0x0000_0000_0012_3456_7B, out_rdy=1 -> out_vld=1 with identical data 1 cycle later; pkt_count=1; in_rdy[1] stays 0.
- Contention: both inputs valid continuously for 8 cycles, out_rdy=1 -> grant order 0,1,0,1,…; 4 packets from each input; pkt_count=8; one output packet per cycle with no bubbles.
- Backpressure:
  - out_rdy=0 for 5 cycles with both inputs valid -> out_data held stable, both in_rdy=0, last_grant unchanged.
  - Then out_rdy=1 -> the next grant goes to the input after the one held.
- Masking: enable=2'b01 with in1 valid carrying 0xAA… -> in_rdy[1]=0 indefinitely and in1's packet never appears at the output. Setting enable=2'b11 -> in1's packet delivered within 2 cycles.
- Reset mid-stream: assert rst while out_vld=1 and out_rdy=0 -> out_vld=0 and pkt_count=0 immediately. After release, with both inputs valid, input 0 is granted first.
- Wrap: preload 65535 transfers (or force pkt_count=0xFFFF), then send one packet -> pkt_count=0x0000.

Source files
------------

// File: rtl/spio_aer_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// spio_aer_pkt_arbiter
//
// Merges SpiNNaker packet streams from NUM_IN AER-to-SpiNNaker mappers onto one
// SpiNNaker link transmitter packet interface. Arbitration is fair round-robin.
// Each input has an enable mask. The merged output is registered, so a full
// packet can be forwarded every cycle. Packet contents, including parity, pass
// through untouched.
//
// Ports:
//   rst        in   asynchronous active-high reset
//   clk        in   clock
//   in_enable  in   [NUM_IN]            per-input enable mask (quasi-static)
//   in_data    in   [NUM_IN*PKT_BITS]   input packets, input i at [i*PKT_BITS +: PKT_BITS]
//   in_vld     in   [NUM_IN]            per-input valid
//   in_rdy     out  [NUM_IN]            per-input ready (at most one high)
//   out_data   out  [PKT_BITS]          merged packet (registered)
//   out_vld    out                      merged valid (registered)
//   out_rdy    in                       downstream ready
//   pkt_count  out  [16]                packets accepted into the output register (wraps)
// -----------------------------------------------------------------------------
module spio_aer_pkt_arbiter #(
  parameter int NUM_IN   = 2,
  parameter int PKT_BITS = 72
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic [NUM_IN-1:0]          in_enable,
  input  logic [NUM_IN*PKT_BITS-1:0] in_data,
  input  logic [NUM_IN-1:0]          in_vld,
  output logic [NUM_IN-1:0]          in_rdy,
  output logic [PKT_BITS-1:0]        out_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [15:0]                pkt_count
);

  localparam int GW = $clog2(NUM_IN);

  generate
    if (NUM_IN < 2 || NUM_IN > 4) begin : g_bad_num_in
      $error("spio_aer_pkt_arbiter: NUM_IN must be in 2..4");
    end
  endgenerate

  logic [PKT_BITS-1:0] in_pkt [NUM_IN];
  logic [NUM_IN-1:0]   req;
  logic [NUM_IN-1:0]   grant_oh;
  logic                grant_vld;
  logic [GW-1:0]       grant_idx;
  logic [GW:0]         search_idx;
  logic                load;

  logic [PKT_BITS-1:0] out_data_reg;
  logic                out_vld_reg;
  logic [GW-1:0]       last_grant_reg;
  logic [15:0]         pkt_count_reg;

  // The output register can take a packet when it is empty or being drained
  // in this same cycle, which is what gives back-to-back transfers without
  // bubbles.
  assign load = !out_vld_reg || out_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign in_pkt[gi] = in_data[gi*PKT_BITS +: PKT_BITS];
      assign req[gi]    = in_vld[gi] && in_enable[gi];
      assign in_rdy[gi] = load && grant_oh[gi];
    end
  endgenerate

  // Round-robin search: visit last_grant+1, last_grant+2, ... and wrap. The
  // input that was granted last is checked last. The first requester found
  // wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      search_idx = {1'b0, last_grant_reg} + (GW+1)'(k);
      if (search_idx >= (GW+1)'(NUM_IN)) begin
        search_idx = search_idx - (GW+1)'(NUM_IN);
      end
      if (!grant_vld && req[search_idx[GW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = search_idx[GW-1:0];
      end
    end
    grant_oh = grant_vld ? (NUM_IN'(1) << grant_idx) : '0;
  end

  // Priority (last_grant) advances only on a real input transfer. A stalled
  // output therefore never skips an input's turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_vld_reg    <= 1'b0;
      last_grant_reg <= GW'(NUM_IN - 1);
      pkt_count_reg  <= '0;
    end else if (load) begin
      if (grant_vld) begin
        out_data_reg   <= in_pkt[grant_idx];
        out_vld_reg    <= 1'b1;
        last_grant_reg <= grant_idx;
        pkt_count_reg  <= pkt_count_reg + 16'd1;
      end else begin
        out_vld_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_vld   = out_vld_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_spio_aer_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spio_aer_pkt_arbiter
//
// Directed, table-driven bench for spio_aer_pkt_arbiter with NUM_IN=2.
// Each table row gives the inputs for one cycle. It also gives the expected
// in_rdy before the edge and the expected out_vld, out_data and pkt_count
// after the edge. Hand-written sequences follow the table. They cover an
// asynchronous reset in mid-stream and the pkt_count wrap.
// -----------------------------------------------------------------------------
module tb_spio_aer_pkt_arbiter;

  localparam int NUM_IN   = 2;
  localparam int PKT_BITS = 72;
  localparam int NVEC     = 25;

  localparam logic [71:0] D0 = 72'h00000000001234567B;
  localparam logic [71:0] D1 = 72'hAAAAAAAAAAAAAAAAAA;

  logic                       rst;
  logic                       clk;
  logic [NUM_IN-1:0]          in_enable;
  logic [NUM_IN*PKT_BITS-1:0] in_data;
  logic [NUM_IN-1:0]          in_vld;
  logic [NUM_IN-1:0]          in_rdy;
  logic [PKT_BITS-1:0]        out_data;
  logic                       out_vld;
  logic                       out_rdy;
  logic [15:0]                pkt_count;

  spio_aer_pkt_arbiter #(.NUM_IN(NUM_IN), .PKT_BITS(PKT_BITS)) dut (
    .rst       (rst),
    .clk       (clk),
    .in_enable (in_enable),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  vld;
    logic        ordy;
    logic [1:0]  exp_rdy;
    logic        exp_ovld;
    logic [71:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [NVEC];
  int   nvec;
  int   checks;
  int   errors;

  task automatic add(input logic [1:0] en, input logic [1:0] vld, input logic ordy,
                     input logic [1:0] exp_rdy, input logic exp_ovld,
                     input logic [71:0] exp_data, input logic [15:0] exp_cnt);
    vecs[nvec].en       = en;
    vecs[nvec].vld      = vld;
    vecs[nvec].ordy     = ordy;
    vecs[nvec].exp_rdy  = exp_rdy;
    vecs[nvec].exp_ovld = exp_ovld;
    vecs[nvec].exp_data = exp_data;
    vecs[nvec].exp_cnt  = exp_cnt;
    nvec++;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    nvec   = 0;

    //   en     vld    ordy  rdy    ovld  data cnt
    // single source: input 0 wins the first arbitration
    add(2'b11, 2'b01, 1'b1, 2'b01, 1'b1, D0, 16'd1);
    add(2'b11, 2'b00, 1'b1, 2'b00, 1'b0, D0, 16'd1);
    // contention: grants alternate with no bubbles
    add(2'b11, 2'b11, 1'b1, 2'b10, 1'b1, D1, 16'd2);
    add(2'b11, 2'b11, 1'b1, 2'b01, 1'b1, D0, 16'd3);
    add(2'b11, 2'b11, 1'b1, 2'b10, 1'b1, D1, 16'd4);
    add(2'b11, 2'b11, 1'b1, 2'b01, 1'b1, D0, 16'd5);
    add(2'b11, 2'b11, 1'b1, 2'b10, 1'b1, D1, 16'd6);
    add(2'b11, 2'b11, 1'b1, 2'b01, 1'b1, D0, 16'd7);
    add(2'b11, 2'b11, 1'b1, 2'b10, 1'b1, D1, 16'd8);
    add(2'b11, 2'b11, 1'b1, 2'b01, 1'b1, D0, 16'd9);
    // backpressure: everything holds for 5 cycles
    for (int i = 0; i < 5; i++) add(2'b11, 2'b11, 1'b0, 2'b00, 1'b1, D0, 16'd9);
    // release: the next grant goes to the input after the held one
    add(2'b11, 2'b11, 1'b1, 2'b10, 1'b1, D1, 16'd10);
    // masking: input 1 is disabled and stalls
    add(2'b01, 2'b10, 1'b1, 2'b00, 1'b0, D1, 16'd10);
    add(2'b01, 2'b10, 1'b1, 2'b00, 1'b0, D1, 16'd10);
    add(2'b01, 2'b11, 1'b1, 2'b01, 1'b1, D0, 16'd11);
    add(2'b01, 2'b10, 1'b1, 2'b00, 1'b0, D0, 16'd11);
    // re-enable: input 1 is delivered
    add(2'b11, 2'b10, 1'b1, 2'b10, 1'b1, D1, 16'd12);
    // disabling does not drop the packet already in the output register
    add(2'b11, 2'b01, 1'b0, 2'b00, 1'b1, D1, 16'd12);
    add(2'b00, 2'b01, 1'b1, 2'b00, 1'b0, D1, 16'd12);
    // empty output loads even while out_rdy is low
    add(2'b11, 2'b00, 1'b0, 2'b00, 1'b0, D1, 16'd12);
    add(2'b11, 2'b01, 1'b0, 2'b01, 1'b1, D0, 16'd13);

    rst       = 1'b1;
    in_enable = 2'b00;
    in_vld    = 2'b00;
    in_data   = {D1, D0};
    out_rdy   = 1'b0;
    #12;
    chk("reset_out_vld",   72'(out_vld),   72'd0);
    chk("reset_out_data",  out_data,       72'd0);
    chk("reset_pkt_count", 72'(pkt_count), 72'd0);
    rst = 1'b0;

    for (int v = 0; v < nvec; v++) begin
      in_enable = vecs[v].en;
      in_vld    = vecs[v].vld;
      out_rdy   = vecs[v].ordy;
      #1;
      chk($sformatf("vec%0d_in_rdy", v), 72'(in_rdy), 72'(vecs[v].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_vld", v),   72'(out_vld),   72'(vecs[v].exp_ovld));
      chk($sformatf("vec%0d_out_data", v),  out_data,       vecs[v].exp_data);
      chk($sformatf("vec%0d_pkt_count", v), 72'(pkt_count), 72'(vecs[v].exp_cnt));
      $display("vec %0d: en=%b vld=%b ordy=%b in_rdy=%b out_vld=%b out_data=%h cnt=%0d",
               v, in_enable, in_vld, out_rdy, in_rdy, out_vld, out_data, pkt_count);
    end

    // Asynchronous reset while a packet sits stalled in the output register.
    in_enable = 2'b11;
    in_vld    = 2'b11;
    out_rdy   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_vld",   72'(out_vld),   72'd0);
    chk("midrst_pkt_count", 72'(pkt_count), 72'd0);
    chk("midrst_out_data",  out_data,       72'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("postrst_in_rdy", 72'(in_rdy), 72'(2'b01));
    @(posedge clk);
    #1;
    chk("postrst_out_data",  out_data,       D0);
    chk("postrst_pkt_count", 72'(pkt_count), 72'd1);
    $display("reset seq: in_rdy=%b out_vld=%b out_data=%h cnt=%0d", in_rdy, out_vld, out_data, pkt_count);

    // Stream from input 0 until the counter saturates its range, then wrap.
    in_vld  = 2'b01;
    out_rdy = 1'b1;
    cyc     = 0;
    while (pkt_count !== 16'hFFFF && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("wrap_reach_ffff", 72'(pkt_count), 72'hFFFF);
    @(posedge clk);
    #1;
    chk("wrap_to_zero", 72'(pkt_count), 72'h0000);
    chk("wrap_out_vld", 72'(out_vld),   72'd1);
    $display("wrap seq: cycles=%0d cnt=%0d out_vld=%b", cyc, pkt_count, out_vld);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
